uart_tx_buf: RTL and testbench

//  Parametrised RS-232 transmitter that supersedes the fixed 8N1, two-rate design.
//  - Data width and FIFO depth are set by parameters.
//  - Bit rate comes from a runtime divisor; stop-bit count is selectable.
//  - A TX FIFO lets the CPU I/O port queue bytes without polling between every character.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_fifo.sv | 69 ++++++
 rtl/uart_tx_buf.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_buf.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: transmitter FSM state encoding and a helper
// returning standard bit-period divisors for a 37.5 MHz system clock.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam int unsigned DIV_19K2  = 1953;
  localparam int unsigned DIV_115K2 = 325;

  // Divisor for the two standard rates; any other rate falls back to 19.2k.
  function automatic int unsigned std_div(input int unsigned baud);
    return (baud == 115200) ? DIV_115K2 : DIV_19K2;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// DEPTH x DW synchronous FIFO with combinational head read.
// Ports: push/wdata in, pop in, rdata (head), level, full, empty.
module uart_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign level = cnt_q;
  assign rdata = mem_q[rp_q];

  // A pop frees the head slot this cycle, so a full FIFO still
  // accepts a simultaneous push.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wp_q] = wdata;
      wp_d        = wp_q + 1'b1;
    end
    if (pop_ok) begin
      rp_d = rp_q + 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered RS-232 transmitter: FIFO-fed, runtime divisor, 1/2 stop bits.
// Ports: clk, rst (async low), wr/data push, div, stop2, rdy, idle,
// level, ovf (sticky drop), TxD. Optional parity via UART_TX_PARITY_EN
// (adds par_en, par_odd).
module uart_tx_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int DIVW  = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [DW-1:0]          data,
  input  logic [DIVW-1:0]        div,
  input  logic                   stop2,
`ifdef UART_TX_PARITY_EN
  input  logic                   par_en,
  input  logic                   par_odd,
`endif
  output logic                   rdy,
  output logic                   idle,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  output logic                   TxD
);
  import uart_pkg::*;

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  state_e          state_q, state_d;
  logic [DIVW-1:0] tick_q, tick_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DW-1:0]   sh_q, sh_d;
  logic            s2_q, s2_d;
  logic            stop_n_q, stop_n_d;
  logic            pen_q, pen_d;
  logic            par_q, par_d;
  logic            ovf_q, ovf_d;

  logic [DW-1:0]   head;
  logic            full, empty, pop, load, tick_end;

  uart_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr),
    .pop   (pop),
    .wdata (data),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign rdy      = ~full;
  assign idle     = empty & (state_q == S_IDLE);
  assign ovf      = ovf_q;
  assign tick_end = (tick_q == div_q);
  assign pop      = load;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    s2_d     = s2_q;
    stop_n_d = stop_n_q;
    pen_d    = pen_q;
    par_d    = par_q;
    load     = 1'b0;
    ovf_d    = ovf_q | (wr & full & ~pop);

    if (state_q != S_IDLE) begin
      tick_d = tick_end ? '0 : tick_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        load = ~empty;
      end
      S_START: begin
        if (tick_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tick_end) begin
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 1'b1;
          if (bit_q == BW'(DW-1)) begin
            state_d  = pen_q ? S_PARITY : S_STOP;
            stop_n_d = 1'b0;
          end
        end
      end
      S_PARITY: begin
        if (tick_end) begin
          state_d  = S_STOP;
          stop_n_d = 1'b0;
        end
      end
      S_STOP: begin
        if (tick_end) begin
          if (s2_q && !stop_n_q) begin
            stop_n_d = 1'b1;
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame settings are captured only when a character is popped,
    // so mid-frame changes wait for the next character.
    if (load) begin
      state_d = S_START;
      tick_d  = '0;
      sh_d    = head;
      div_d   = (div == '0) ? DIVW'(1) : div;
      s2_d    = stop2;
`ifdef UART_TX_PARITY_EN
      pen_d   = par_en;
      par_d   = (^head) ^ par_odd;
`else
      pen_d   = 1'b0;
      par_d   = 1'b0;
`endif
    end
  end

  always_comb begin
    unique case (state_q)
      S_START:  TxD = 1'b0;
      S_DATA:   TxD = sh_q[0];
      S_PARITY: TxD = par_q;
      default:  TxD = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      div_q    <= DIVW'(1);
      bit_q    <= '0;
      sh_q     <= '0;
      s2_q     <= 1'b0;
      stop_n_q <= 1'b0;
      pen_q    <= 1'b0;
      par_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      s2_q     <= s2_d;
      stop_n_q <= stop_n_d;
      pen_q    <= pen_d;
      par_q    <= par_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf: expected frames queued at write
// time, a line monitor decodes TxD cycle by cycle and compares.
module tb_uart_tx_buf;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DIVW  = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wr = 1'b0;
  logic [DW-1:0]   data = '0;
  logic [DIVW-1:0] div = 12'd3;
  logic            stop2 = 1'b0;
  logic            par_en = 1'b0;
  logic            par_odd = 1'b0;
  logic            rdy, idle, ovf, TxD;
  logic [2:0]      level;

  uart_tx_buf #(.DW(DW), .DEPTH(DEPTH), .DIVW(DIVW)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .data  (data),
    .div   (div),
    .stop2 (stop2),
`ifdef UART_TX_PARITY_EN
    .par_en  (par_en),
    .par_odd (par_odd),
`endif
    .rdy   (rdy),
    .idle  (idle),
    .level (level),
    .ovf   (ovf),
    .TxD   (TxD)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    int         per;
    bit         s2;
    bit         par;
    bit         odd;
    bit         b2b;
    bit         last;
    int         wc;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_busy = 0;
  int   last_end = 0;
  int   last_start = 0;
  int   last_wc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Line level of bit slot idx of a frame, from the RS-232 frame rules.
  function automatic logic exp_bit(input exp_t e, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return e.d[idx-1];
    if (e.par && idx == 9) return (^e.d) ^ e.odd;
    return 1'b1;
  endfunction

  function automatic int frame_len(input exp_t e);
    return (1 + 8 + (e.par ? 1 : 0) + (e.s2 ? 2 : 1)) * e.per;
  endfunction

  // Monitor
  initial begin
    exp_t e;
    int   len, bad, st;
    bit   ab;
    forever begin
      @(negedge clk);
      if (rst && TxD === 1'b0) begin
        mon_busy = 1;
        st = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          for (int k = 0; k < 2000 && TxD !== 1'b1; k++) @(negedge clk);
        end else begin
          e = exp_q.pop_front();
          len = frame_len(e);
          bad = 0;
          ab = 0;
          for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            if (!rst) begin
              ab = 1;
              break;
            end
            if (TxD !== exp_bit(e, k / e.per)) bad++;
          end
          if (!ab) begin
            chk($sformatf("frame_%02h_bad_cycles", e.d), bad, 0);
            if (e.wc >= 0) chk("start_latency", st - e.wc, 2);
            if (e.b2b) chk("b2b_gap", st - last_end, 1);
            last_start = st;
            last_end = cyc;
            if (e.last) begin
              @(negedge clk);
              if (rst) chk("idle_after_stop", idle, 1);
            end
          end
        end
        mon_busy = 0;
      end
    end
  end

  task automatic burst(input logic [7:0] b [8], input int n,
                       input int nacc, input int per, input bit s2);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr = 1'b1;
      data = b[i];
      if (i == 0) last_wc = cyc;
      if (i < nacc) begin
        e.d = b[i];
        e.per = per;
        e.s2 = s2;
        e.par = par_en;
        e.odd = par_odd;
        e.b2b = (i > 0);
        e.last = (i == nacc - 1);
        e.wc = (i == 0) ? cyc : -1;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy || !idle) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({"timeout_", tag}, (n >= 20000) ? 1 : 0, 0);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] b [8];
    exp_t e;
    int w0, n, per, dv;

    repeat (3) @(negedge clk);
    chk("rst_txd", TxD, 1);
    chk("rst_rdy", rdy, 1);
    chk("rst_idle", idle, 1);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single 0xA5 frame
    b[0] = 8'hA5;
    burst(b, 1, 1, 4, 0);
    wait_done("t1");
    chk("t1_frame_clocks", last_end - last_start + 1, 40);

    // Six consecutive writes: last one dropped
    for (int i = 0; i < 6; i++) b[i] = 8'h10 + 8'(i * 37);
    burst(b, 6, 5, 4, 0);
    chk("t2_level_peak", level, 4);
    chk("t2_ovf", ovf, 1);
    chk("t2_rdy", rdy, 0);
    wait_done("t2");
    chk("t2_ovf_sticky", ovf, 1);
    chk("t2_level_drained", level, 0);

    // Two stop bits
    stop2 = 1'b1;
    b[0] = 8'h00;
    burst(b, 1, 1, 4, 1);
    wait_done("t3");
    chk("t3_frame_clocks", last_end - last_start + 1, 44);
    stop2 = 1'b0;

    // Divisor change mid-frame applies to the next frame only
    @(negedge clk);
    wr = 1'b1;
    data = 8'hC3;
    w0 = cyc;
    e = '{d: 8'hC3, per: 4, s2: 0, par: 0, odd: 0, b2b: 0, last: 0, wc: cyc};
    exp_q.push_back(e);
    @(negedge clk);
    data = 8'h3C;
    e = '{d: 8'h3C, per: 8, s2: 0, par: 0, odd: 0, b2b: 1, last: 1, wc: -1};
    exp_q.push_back(e);
    @(negedge clk);
    wr = 1'b0;
    for (int k = 0; k < 100 && cyc < w0 + 12; k++) @(negedge clk);
    div = 12'd7;
    wait_done("t5");
    chk("t5_second_frame_clocks", last_end - last_start + 1, 80);
    div = 12'd3;

    // Reset in the middle of a frame
    b[0] = 8'h35;
    burst(b, 1, 1, 4, 0);
    for (int k = 0; k < 100 && cyc < last_wc + 19; k++) @(negedge clk);
    chk("t4_txd_before_rst", TxD, 0);
    #1 rst = 1'b0;
    #1;
    chk("t4_txd", TxD, 1);
    chk("t4_level", level, 0);
    chk("t4_ovf", ovf, 0);
    chk("t4_idle", idle, 1);
    chk("t4_rdy", rdy, 1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    b[0] = 8'h5A;
    burst(b, 1, 1, 4, 0);
    wait_done("t4b");

    // Randomised bursts
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 4);
      dv = $urandom_range(0, 5);
      per = ((dv == 0) ? 1 : dv) + 1;
      div = 12'(dv);
      stop2 = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
      burst(b, n, n, per, stop2);
      wait_done("rand");
    end
    chk("final_ovf", ovf, 0);

`ifdef UART_TX_PARITY_EN
    div = 12'd3;
    stop2 = 1'b0;
    par_en = 1'b1;
    par_odd = 1'b0;
    b[0] = 8'hA5;
    burst(b, 1, 1, 4, 0);
    wait_done("par_even");
    chk("par_even_clocks", last_end - last_start + 1, 44);
    par_odd = 1'b1;
    burst(b, 1, 1, 4, 0);
    wait_done("par_odd");
    chk("par_odd_clocks", last_end - last_start + 1, 44);
    par_en = 1'b0;
    par_odd = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
